// File: rtl/layer3_fc_pkg.sv
// Shared widths, saturation limits and FSM encoding for the fully-connected layer.
package layer3_fc_pkg;
  localparam int DATA_W = 18;
  localparam int ACC_W  = 42;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ADDR_W = 8;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/fc_sat_relu.sv
// Combinational fixed-point rescale: arithmetic shift, saturate to DATA_W, optional ReLU.
module fc_sat_relu
  import layer3_fc_pkg::*;
#(
  parameter int FRAC = 8,
  parameter int RELU = 1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result
);
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > ACC_W'(SAT_MAX))
      sat = SAT_MAX;
    else if (shifted < ACC_W'(SAT_MIN))
      sat = SAT_MIN;
    else
      sat = shifted[DATA_W-1:0];
    if (RELU != 0 && sat[DATA_W-1])
      result = '0;
    else
      result = sat;
  end
endmodule

// File: rtl/layer3_fc.sv
// Fully-connected layer: buffers one pooled frame, then runs one bias+MAC pass per neuron
// against an external 1-cycle-latency weight/bias ROM.
module layer3_fc
  import layer3_fc_pkg::*;
#(
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 10,
  parameter int FRAC    = 8,
  parameter int RELU    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] datain,
  input  logic                     pool_out,
  input  logic                     pool_finish,
  output logic [ADDR_W-1:0]        weight_addr,
  input  logic signed [DATA_W-1:0] weight_data,
  output logic signed [DATA_W-1:0] dataout,
  output logic                     fc_out,
  output logic                     fc_finish,
  output logic                     busy,
  output logic                     err
);
  localparam int CNT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int K_W   = $clog2(NUM_IN + 1);
  localparam int J_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [K_W-1:0]             k;
  logic [J_W-1:0]             j;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   buffer [NUM_IN];
  logic signed [PROD_W-1:0]   prod;
  logic signed [DATA_W-1:0]   result;
  logic                       accept;

  // The buffer rotates once per product, so buffer[0] always pairs with the returning
  // weight; NUM_IN rotations per neuron restore the original order.
  assign prod   = PROD_W'(buffer[0]) * PROD_W'(weight_data);
  assign accept = pool_out && (state == FILL) && !busy;

  fc_sat_relu #(.FRAC(FRAC), .RELU(RELU)) u_sat (.acc(acc), .result(result));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      cnt         <= '0;
      k           <= '0;
      j           <= '0;
      acc         <= '0;
      weight_addr <= '0;
      dataout     <= '0;
      fc_out      <= 1'b0;
      fc_finish   <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else if (enable) begin
      fc_out    <= 1'b0;
      fc_finish <= 1'b0;
      if (pool_out && !accept)
        err <= 1'b1;
      if (accept && pool_finish && int'(cnt) != NUM_IN - 1)
        err <= 1'b1;
      case (state)
        FILL: begin
          busy <= 1'b0;
          if (accept) begin
            buffer[cnt] <= datain;
            if (int'(cnt) == NUM_IN - 1) begin
              cnt         <= '0;
              j           <= '0;
              k           <= '0;
              busy        <= 1'b1;
              weight_addr <= ADDR_W'(NUM_OUT * NUM_IN);
              state       <= MAC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MAC: begin
          if (int'(k) == 1) begin
            acc <= ACC_W'(weight_data) <<< FRAC;
          end else if (int'(k) > 1) begin
            acc <= acc + ACC_W'(prod);
            for (int unsigned i = 0; i < NUM_IN - 1; i++)
              buffer[i] <= buffer[i+1];
            buffer[NUM_IN-1] <= buffer[0];
          end
          if (int'(k) == NUM_IN)
            state <= DRAIN;
          else
            weight_addr <= ADDR_W'(int'(j) * NUM_IN + int'(k));
          k <= k + 1'b1;
        end
        DRAIN: begin
          acc <= acc + ACC_W'(prod);
          for (int unsigned i = 0; i < NUM_IN - 1; i++)
            buffer[i] <= buffer[i+1];
          buffer[NUM_IN-1] <= buffer[0];
          state <= OUT;
        end
        OUT: begin
          dataout <= result;
          fc_out  <= 1'b1;
          k       <= '0;
          if (int'(j) == NUM_OUT - 1) begin
            fc_finish <= 1'b1;
            state     <= FILL;
          end else begin
            j           <= j + 1'b1;
            weight_addr <= ADDR_W'(NUM_OUT * NUM_IN + int'(j) + 1);
            state       <= MAC;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/layer3_fc.md
LAYER3_FC -- requirements
Module: layer3_fc

Interface
REQ-001 SHALL have parameter NUM_IN, default 16, number of pooled inputs per frame (one 4x4 pooled map).
REQ-002 SHALL have parameter NUM_OUT, default 10, number of output neurons.
REQ-003 SHALL have parameter FRAC, default 8, fractional bits of the signed fixed-point data, weight and bias format.
REQ-004 SHALL have parameter RELU, default 1; 1 applies ReLU to each output, 0 bypasses it.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, clock enable; when low, all state, counters and outputs hold.
REQ-008 SHALL have port datain, input, 18, signed pooled sample.
REQ-009 SHALL have port pool_out, input, 1, datain valid strobe from the upstream maxpool.
REQ-010 SHALL have port pool_finish, input, 1, upstream last-sample marker (checked only, never used to start compute).
REQ-011 SHALL have port weight_addr, output, 8, registered address to the external weight/bias ROM.
REQ-012 SHALL have port weight_data, input, 18, signed ROM data, valid exactly 1 cycle after weight_addr.
REQ-013 SHALL have port dataout, output, 18, signed neuron result.
REQ-014 SHALL have port fc_out, output, 1, one-cycle dataout valid strobe.
REQ-015 SHALL have port fc_finish, output, 1, one-cycle pulse coincident with the last neuron's fc_out.
REQ-016 SHALL have port busy, output, 1, high from the NUM_IN-th accepted sample until fc_finish inclusive.
REQ-017 SHALL have port err, output, 1, sticky flag for protocol violations.

Function
REQ-018 FSM states SHALL be FILL, MAC, DRAIN and OUT; reset enters FILL.
REQ-019 In FILL, each enable&pool_out cycle SHALL write datain to buffer[cnt] and increment cnt.
REQ-020 When the NUM_IN-th sample is written, the FSM SHALL enter MAC with neuron index j=0 and clear cnt.
REQ-021 ROM map: the weight for (j,i) SHALL be at address j*NUM_IN+i; the bias for j SHALL be at NUM_OUT*NUM_IN+j.
REQ-022 MAC SHALL last NUM_IN+1 cycles: k=0 issues the bias address, k=1..NUM_IN issue weight addresses i=k-1.
REQ-023 The accumulator SHALL be 42-bit signed; on the data return for k=0, acc SHALL be loaded with sign-extended bias shifted left FRAC.
REQ-024 On the data return for each k>=1, acc SHALL accumulate buffer[k-1]*weight_data as a full 36-bit signed product.
REQ-025 DRAIN SHALL last one cycle and absorb the final ROM return.
REQ-026 OUT SHALL last one cycle: dataout = acc arithmetic-shifted right by FRAC (truncate toward minus infinity), saturated to [-131072, 131071], then clamped to 0 if negative and RELU=1; fc_out=1.
REQ-027 After OUT, the FSM SHALL go to MAC with j+1 if j<NUM_OUT-1, otherwise to FILL with fc_finish=1 in that OUT cycle.
REQ-028 Timing: with NUM_IN=16, fc_out for neuron j SHALL fire exactly 19*(j+1) enabled cycles after the enabled cycle that accepted the 16th sample.
REQ-029 dataout SHALL hold its value between fc_out pulses.
REQ-030 While busy, pool_out SHALL be ignored (no buffer write) and SHALL set err.
REQ-031 pool_finish high on an accepted sample with cnt != NUM_IN-1 SHALL set err.
REQ-032 pool_finish low on the NUM_IN-th accepted sample SHALL NOT set err.
REQ-033 With enable low, cycle counting for REQ-028 SHALL pause and the ROM address SHALL hold.

Reset
REQ-034 Reset SHALL set dataout=0, fc_out=0, fc_finish=0, busy=0, err=0, weight_addr=0, cnt=0, j=0, acc=0 and state FILL, regardless of enable.
REQ-035 Reset mid-MAC SHALL abandon the frame with no fc_out; the next frame SHALL start from an empty buffer.

Structure
REQ-036 A shared package SHALL hold the 18-bit data width, the accumulator width, the FSM state encoding and the sat/ReLU width constants.
REQ-037 A sub-module fc_sat_relu SHALL perform the combinational shift, saturation and ReLU.

Verification
REQ-038 Verify: 16 samples of 256, all weights 256, biases 0 -> ten fc_out with dataout=4096, fc_finish on the 10th, first fc_out 19 cycles after the 16th sample.
REQ-039 Verify: samples 131071, weights 131071 -> dataout=131071 (saturated), err=0.
REQ-040 Verify: weights -256, biases 0, samples 256, RELU=1 -> dataout=0; with RELU=0 -> dataout=-4096.
REQ-041 Verify: bias 512 (2.0), weights 0 -> dataout=512 for every neuron.
REQ-042 Verify: pool_out pulsed during busy -> err=1 sticky and results unchanged; pool_finish on the 5th sample -> err=1.
REQ-043 Verify: reset at MAC cycle 7 -> no fc_out and all outputs 0; enable low for 5 cycles mid-MAC -> fc_out delayed by exactly 5 cycles with the same values.
